// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and geometry for the data-cache writeback path.
package dcache_pkg;
  localparam int LINE_WORDS = 16;
  localparam int RBKSZ = 4;
  localparam int MADDR_W = 32;
  localparam int LADDR_W = 6;
  localparam int BEATS = LINE_WORDS / RBKSZ;
  localparam int WADDR_W = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1;
  typedef logic [31:0] word_t;
  typedef logic [LADDR_W-1:0] laddr_t;
  typedef logic [WADDR_W-1:0] waddr_t;
  typedef logic [MADDR_W-1:0] maddr_t;
  typedef enum logic [1:0] {IDLE, READ, SEND} wb_state_t;
  function automatic bit is_pow2(int v);
    return v > 0 && (v & (v - 1)) == 0;
  endfunction
endpackage

// File: rtl/dcache_writeback.sv
// dcache_writeback: streams a victim line from the data array to memory; DCACHE_WB_PIPE_EN overlaps reads with sends.
import dcache_pkg::*;
module dcache_writeback #(
  parameter int LINE_WORDS = dcache_pkg::LINE_WORDS,
  parameter int RBKSZ = dcache_pkg::RBKSZ,
  parameter int MADDR_W = dcache_pkg::MADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_req_valid,
  output logic                     wb_req_ready,
  input  laddr_t                   wb_req_laddr,
  input  logic [MADDR_W-1:0]       wb_req_addr,
  output logic                     wb_busy,
  output logic                     wb_done,
  output logic                     cm_re,
  output laddr_t                   cm_laddr,
  output waddr_t                   cm_waddr,
  input  word_t [RBKSZ-1:0]        cm_dout,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [MADDR_W-1:0]       mem_addr,
  output word_t [RBKSZ-1:0]        mem_data,
  output logic                     mem_last
);
  localparam int N_BEATS = LINE_WORDS / RBKSZ;
  localparam int B_W = N_BEATS > 1 ? $clog2(N_BEATS) : 1;
  if (LINE_WORDS % RBKSZ != 0 || !is_pow2(LINE_WORDS) || !is_pow2(RBKSZ)) begin : g_bad_cfg
    $error("dcache_writeback: LINE_WORDS and RBKSZ must be powers of two with RBKSZ dividing LINE_WORDS");
  end
  wb_state_t state, state_n;
  logic [B_W-1:0] beat, beat_n;
  laddr_t laddr_q;
  logic [MADDR_W-1:0] addr_q;
  logic done_q, done_n, send, last, fire, pipe_re;
  assign send = state == SEND;
  assign last = beat == B_W'(N_BEATS - 1);
  assign fire = send && mem_ready;
`ifdef DCACHE_WB_PIPE_EN
  assign pipe_re = fire && !last;
`else
  assign pipe_re = 1'b0;
`endif
  always_comb begin
    state_n = state;
    beat_n = beat;
    done_n = 1'b0;
    if (state == IDLE && wb_req_valid) begin
      state_n = READ;
      beat_n = '0;
    end
    if (state == READ) state_n = SEND;
    if (fire) begin
      done_n = last;
      state_n = last ? IDLE : (pipe_re ? SEND : READ);
      beat_n = last ? beat : beat + 1'b1;
    end
  end
  // cm_dout holds while cm_re is low, so a stalled beat needs no capture register
  always_comb begin
    wb_req_ready = state == IDLE;
    wb_busy = state != IDLE || done_q;
    wb_done = done_q;
    cm_re = state == READ || pipe_re;
    cm_laddr = laddr_q;
    cm_waddr = waddr_t'(32'(pipe_re ? beat + 1'b1 : beat) * RBKSZ);
    mem_valid = send;
    mem_addr = addr_q + MADDR_W'(32'(beat) * RBKSZ * 4);
    mem_data = send ? cm_dout : '0;
    mem_last = send && last;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat <= '0;
      laddr_q <= '0;
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      beat <= beat_n;
      done_q <= done_n;
      if (wb_req_ready && wb_req_valid) begin
        laddr_q <= wb_req_laddr;
        addr_q <= wb_req_addr;
      end
    end
  end
endmodule

// File: tb/tb_dcache_writeback.sv
// tb_dcache_writeback: directed and randomised-backpressure checks of the writeback engine.
import dcache_pkg::*;
module tb_dcache_writeback;
`ifdef DCACHE_WB_PIPE_EN
  localparam int EXP_LAT = 6;
`else
  localparam int EXP_LAT = 9;
`endif
  typedef struct {
    logic [31:0] addr;
    logic [127:0] data;
    logic last;
  } beat_t;
  logic clk = 0, rst = 1;
  logic wb_req_valid = 0, wb_req_ready, wb_busy, wb_done, cm_re, mem_valid, mem_ready = 0, mem_last;
  laddr_t wb_req_laddr = '0, cm_laddr;
  logic [31:0] wb_req_addr = '0, mem_addr;
  waddr_t cm_waddr;
  word_t [RBKSZ-1:0] cm_dout = '0, mem_data;
  int checks = 0, errors = 0, hs_cnt = 0, exp_done = 0, act_done = 0;
  beat_t q[$];
  logic prev_stall = 0, p_last;
  logic [31:0] p_addr;
  logic [127:0] p_data;
  always #5 clk = ~clk;
  dcache_writeback dut (
    .clk(clk), .rst(rst), .wb_req_valid(wb_req_valid), .wb_req_ready(wb_req_ready),
    .wb_req_laddr(wb_req_laddr), .wb_req_addr(wb_req_addr), .wb_busy(wb_busy), .wb_done(wb_done),
    .cm_re(cm_re), .cm_laddr(cm_laddr), .cm_waddr(cm_waddr), .cm_dout(cm_dout),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_last(mem_last)
  );
  function automatic word_t data_of(laddr_t l, int w);
    return {8'(l) ^ 8'h05, 16'h0, 8'hA0 + 8'(w)};
  endfunction
  function automatic logic [127:0] line_beat(laddr_t l, int b);
    logic [127:0] d;
    for (int i = 0; i < 4; i++) d[i*32 +: 32] = data_of(l, b * 4 + i);
    return d;
  endfunction
  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  always @(posedge clk)
    if (cm_re) for (int i = 0; i < 4; i++) cm_dout[i] <= data_of(cm_laddr, int'(cm_waddr) + i);
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall = 0;
      exp_done = act_done;
    end else begin
      if (wb_req_valid && wb_req_ready) begin
        for (int b = 0; b < 4; b++) q.push_back('{wb_req_addr + 32'(b * 16), line_beat(wb_req_laddr, b), b == 3});
        exp_done++;
      end
      if (wb_done) act_done++;
      if (prev_stall) begin
        chk("stall_valid", mem_valid, 1);
        chk("stall_addr", mem_addr, p_addr);
        chk("stall_data", mem_data, p_data);
        chk("stall_last", mem_last, p_last);
        chk("stall_cm_re", cm_re, 0);
      end
      if (mem_valid && mem_ready) begin
        hs_cnt++;
        if (q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          chk("beat_addr", mem_addr, q[0].addr);
          chk("beat_data", mem_data, q[0].data);
          chk("beat_last", mem_last, q[0].last);
          void'(q.pop_front());
        end
      end
      prev_stall = mem_valid && !mem_ready;
      p_addr = mem_addr;
      p_data = mem_data;
      p_last = mem_last;
    end
  end
  task automatic issue(laddr_t l, logic [31:0] a);
    wb_req_valid = 1;
    wb_req_laddr = l;
    wb_req_addr = a;
    chk("req_ready", wb_req_ready, 1);
    @(posedge clk);
    #1 wb_req_valid = 0;
  endtask
  task automatic wait_done(input bit rnd, output int cyc);
    cyc = 1;
    while (!wb_done && cyc < 300) begin
      @(posedge clk);
      #1 cyc++;
      if (rnd) mem_ready = 1'($urandom_range(0, 1));
    end
    if (!wb_done) chk("done_timeout", 0, 1);
  endtask
  initial begin
    int c, base;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", wb_req_ready, 1);
    chk("rst_busy", wb_busy, 0);
    chk("rst_done", wb_done, 0);
    chk("rst_cm_re", cm_re, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_last", mem_last, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cm_addr", {cm_laddr, cm_waddr}, 0);
    chk("rst_mem_data", mem_data, 0);
    rst = 0;
    mem_ready = 1;
    @(posedge clk);
    #1 issue(6'd5, 32'h1000);
    chk("first_read", {cm_re, cm_laddr, cm_waddr}, {1'b1, 6'd5, 4'd0});
    wait_done(0, c);
    chk("latency", c, EXP_LAT);
    chk("busy_in_done", wb_busy, 1);
    @(posedge clk);
    #1 base = hs_cnt;
    issue(6'd5, 32'h1000);
    for (int i = 0; i < 40 && hs_cnt < base + 2; i++) @(posedge clk);
    #1 mem_ready = 0;
    @(negedge clk);
    for (int i = 0; i < 10 && !mem_valid; i++) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk);
      chk("bp_valid", mem_valid, 1);
      chk("bp_addr", mem_addr, 32'h1020);
      chk("bp_data", mem_data, 128'h000000AB_000000AA_000000A9_000000A8);
      chk("bp_cm_re", cm_re, 0);
    end
    @(posedge clk);
    #1 mem_ready = 1;
    wait_done(0, c);
    chk("bp_beats", hs_cnt - base, 4);
    issue(6'd3, 32'h4000);
    wait_done(0, c);
    issue(6'd9, 32'h2000);
    chk("b2b_read", {cm_re, cm_laddr}, {1'b1, 6'd9});
    wait_done(0, c);
    chk("b2b_latency", c, EXP_LAT);
    @(posedge clk);
    #1 base = hs_cnt;
    issue(6'd7, 32'h3000);
    for (int i = 0; i < 40 && hs_cnt < base + 2; i++) @(posedge clk);
    #1 rst = 1;
    mem_ready = 0;
    @(posedge clk);
    #1 rst = 0;
    mem_ready = 1;
    chk("abort_valid", mem_valid, 0);
    chk("abort_ready", wb_req_ready, 1);
    chk("abort_busy", wb_busy, 0);
    chk("abort_done", wb_done, 0);
    @(posedge clk);
    #1 chk("abort_no_done", wb_done, 0);
    issue(6'd2, 32'h5000);
    wait_done(0, c);
    chk("post_abort_latency", c, EXP_LAT);
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1 issue(6'($urandom), $urandom & 32'hFFFF_FFC0);
      wait_done(1, c);
    end
    mem_ready = 1;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_cm_re", cm_re, 0);
      chk("idle_valid", mem_valid, 0);
      chk("idle_busy", wb_busy, 0);
    end
    chk("done_count", act_done, exp_done);
    chk("pending_beats", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
